// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter_pkg: shared state type, defaults and requester indices for the BRAM port arbiter
package bram_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BURST, TURN} state_t;
  localparam int NREQ_DEF = 3;
  localparam int MAX_BURST_DEF = 16;
  localparam int IDLE_TIMEOUT_DEF = 16;
  localparam int REQ_LOAD = 0;
  localparam int REQ_STORE = 1;
  localparam int REQ_HOST = 2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bram_rr_select.sv
// bram_rr_select: combinational round-robin pick of the first active request at or after ptr
module bram_rr_select
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);
  always_comb begin
    onehot = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        onehot = '0;
        onehot[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin burst arbiter sharing one BRAM port among NREQ requesters
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0][31:0] REQ_ADDR,
  input  logic [NREQ-1:0][31:0] REQ_DIN,
  input  logic [NREQ-1:0][3:0] REQ_WE,
  input  logic [NREQ-1:0]      REQ_LAST,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      RVALID,
  output logic [31:0]          RDATA,
  output logic [31:0]          addrb,
  output logic [31:0]          dinb,
  input  logic [31:0]          doutb,
  output logic                 enb,
  output logic [3:0]           web,
  output logic                 ERR_TIMEOUT
);
  localparam int IW = idx_w(NREQ);
  localparam int BW = idx_w(MAX_BURST);
  localparam int TW = idx_w(IDLE_TIMEOUT);
  state_t state;
  logic [IW-1:0] ptr, owner, pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] idle_cnt;
  logic [31:0] addr_q, din_q;
  logic beat, release_beat, timeout;
  bram_rr_select #(.NREQ(NREQ), .IW(IW)) u_sel (
    .req(REQ), .ptr(ptr), .onehot(pick_oh), .idx(pick_idx)
  );
  assign beat = |(GNT & REQ);
  assign enb = beat;
  assign addrb = beat ? REQ_ADDR[owner] : addr_q;
  assign dinb = beat ? REQ_DIN[owner] : din_q;
  assign web = beat ? REQ_WE[owner] : 4'h0;
  assign RDATA = |RVALID ? doutb : 32'h0;
  assign release_beat = beat && (REQ_LAST[owner] || beat_cnt == BW'(MAX_BURST - 1));
  assign timeout = state == BURST && !REQ[owner] && idle_cnt == TW'(IDLE_TIMEOUT - 1);
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
      GNT <= '0;
      RVALID <= '0;
      ERR_TIMEOUT <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      addr_q <= addrb;
      din_q <= dinb;
      RVALID <= (beat && web == 4'h0) ? GNT : '0;
      case (state)
        IDLE: if (|REQ) begin
          state <= BURST;
          owner <= pick_idx;
          GNT <= pick_oh;
          beat_cnt <= '0;
          idle_cnt <= '0;
        end
        BURST: begin
          beat_cnt <= beat ? beat_cnt + 1'b1 : beat_cnt;
          idle_cnt <= beat ? '0 : idle_cnt + 1'b1;
          if (release_beat || timeout) begin
            state <= TURN;
            GNT <= '0;
            ptr <= owner == IW'(NREQ - 1) ? '0 : owner + 1'b1;
            ERR_TIMEOUT <= ERR_TIMEOUT | timeout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: random and directed traffic checked against a transaction-level arbiter model
module tb_bram_port_arbiter;
  localparam int NREQ = 3;
  localparam int MAX_BURST = 16;
  localparam int IDLE_TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0] req = '0, req_last = '0;
  logic [NREQ-1:0][31:0] req_addr = '0, req_din = '0;
  logic [NREQ-1:0][3:0] req_we = '0;
  logic [NREQ-1:0] gnt, rvalid;
  logic [31:0] rdata, addrb, dinb, doutb = '0;
  logic enb, err_timeout;
  logic [3:0] web;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int n_chk = 0, n_pass = 0, n_to = 0, n_full = 0;
  int m_owner, m_ptr, m_beats, m_idle;
  bit m_turn, m_err;
  logic [NREQ-1:0] m_rv;
  logic [31:0] m_rdata, m_addr, m_din;
  int p_req [NREQ];
  int p_last [NREQ];
  int req_tab [3] = '{95, 60, 3};
  int last_tab [3] = '{0, 15, 60};
  bram_port_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .CLK(clk), .RSTN(rst_n), .REQ(req), .REQ_ADDR(req_addr), .REQ_DIN(req_din),
    .REQ_WE(req_we), .REQ_LAST(req_last), .GNT(gnt), .RVALID(rvalid), .RDATA(rdata),
    .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web), .ERR_TIMEOUT(err_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (enb) begin
      doutb <= mem[addrb[9:2]];
      for (int k = 0; k < 4; k++)
        if (web[k]) mem[addrb[9:2]][8*k+:8] = dinb[8*k+:8];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_ptr = 0;
    m_beats = 0;
    m_idle = 0;
    m_turn = 1'b0;
    m_err = 1'b0;
    m_rv = '0;
    m_addr = '0;
    m_din = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_enb", enb, 0);
    check("rst_web", web, 0);
    check("rst_err", err_timeout, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addrb", addrb, 0);
    check("rst_dinb", dinb, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic release_owner(input int o);
    m_ptr = (o + 1) % NREQ;
    m_owner = -1;
    m_turn = 1'b1;
  endtask
  task automatic step();
    int o;
    logic b;
    @(negedge clk);
    o = m_owner;
    b = (o >= 0) ? req[o] : 1'b0;
    check("gnt", gnt, o >= 0 ? 32'(1) << o : 32'd0);
    check("enb", enb, b);
    check("web", web, b ? req_we[o] : 4'h0);
    check("addrb", addrb, b ? req_addr[o] : m_addr);
    check("dinb", dinb, b ? req_din[o] : m_din);
    check("rvalid", rvalid, m_rv);
    if (m_rv != 0) check("rdata", rdata, m_rdata);
    check("err_timeout", err_timeout, m_err);
    m_rv = '0;
    if (o >= 0) begin
      if (b) begin
        m_addr = req_addr[o];
        m_din = req_din[o];
        if (req_we[o] == 4'h0) begin
          m_rv = NREQ'(1) << o;
          m_rdata = ref_mem[m_addr[9:2]];
        end else begin
          for (int k = 0; k < 4; k++)
            if (req_we[o][k]) ref_mem[m_addr[9:2]][8*k+:8] = m_din[8*k+:8];
        end
        m_beats++;
        m_idle = 0;
        if (req_last[o] || m_beats == MAX_BURST) begin
          if (!req_last[o]) n_full++;
          release_owner(o);
        end
      end else begin
        m_idle++;
        if (m_idle == IDLE_TIMEOUT) begin
          m_err = 1'b1;
          n_to++;
          release_owner(o);
        end
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_beats = 0;
          m_idle = 0;
        end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #2;
    do_reset();
    req = 3'b001;
    req_addr[0] = 32'h10;
    req_we[0] = 4'h0;
    req_last = 3'b001;
    step();
    step();
    req = '0;
    step();
    step();
    req = 3'b010;
    req_we[1] = 4'hF;
    req_din[1] = 32'hA5A5A5A5;
    req_last = '0;
    req_addr[1] = 32'h20;
    step();
    for (int k = 0; k < 4; k++) begin
      req_addr[1] = 32'h20 + 32'(4 * k);
      req_last[1] = k == 3;
      step();
    end
    req = '0;
    step();
    step();
    check("wr_mem8", mem[8], 32'hA5A5A5A5);
    check("wr_mem11", mem[11], 32'hA5A5A5A5);
    req = 3'b010;
    req_we[1] = 4'h0;
    req_addr[1] = 32'h24;
    req_last[1] = 1'b1;
    step();
    step();
    req = '0;
    step();
    step();
    req = 3'b001;
    req_last = '0;
    req_addr[0] = 32'h40;
    for (int k = 0; k < 5; k++) step();
    do_reset();
    req = 3'b111;
    req_we = '0;
    step();
    step();
    check("post_rst_gnt", gnt, 32'h1);
    for (int seg = 0; seg < 20; seg++) begin
      for (int i = 0; i < NREQ; i++) begin
        p_req[i] = req_tab[$urandom_range(0, 2)];
        p_last[i] = last_tab[$urandom_range(0, 2)];
      end
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          req[i] = $urandom_range(0, 99) < p_req[i];
          req_last[i] = $urandom_range(0, 99) < p_last[i];
          req_addr[i] = {22'd0, 8'($urandom), 2'b00};
          req_din[i] = $urandom;
          req_we[i] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        end
        if (seg == 7 && c == 80) do_reset();
        step();
      end
    end
    check("cov_timeout", 32'(n_to > 0), 1);
    check("cov_full_burst", 32'(n_full > 0), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (0 = data load, 1 = result store, 2 = host/debug).
REQ-002 SHALL have parameter MAX_BURST, default 16, beats per grant before forced release.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 16, owner-idle cycles before forced release.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports listed as follows.
- CLK  in  1  clock; all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester request, also beat-valid while granted.
- REQ_ADDR  in  NREQ x 32  per-requester BRAM byte address.
- REQ_DIN  in  NREQ x 32  per-requester write data.
- REQ_WE  in  NREQ x 4  per-requester byte write enables; 0 means read.
- REQ_LAST  in  NREQ  final beat of burst.
- GNT  out  NREQ  one-hot grant, registered.
- RVALID  out  NREQ  read data valid for that requester.
- RDATA  out  32  read data, broadcast to all requesters.
- addrb  out  32  BRAM address.
- dinb  out  32  BRAM write data.
- doutb  in  32  BRAM read data, 1-cycle latency.
- enb  out  1  BRAM enable.
- web  out  4  BRAM byte write enable.
- ERR_TIMEOUT  out  1  sticky flag; set when an idle owner is released.

Function
REQ-005 SHALL implement states IDLE, BURST and TURN.
- IDLE -> BURST when any REQ is high; owner is picked round-robin starting at pointer PTR.
- BURST -> TURN on: a LAST beat, MAX_BURST beats, or IDLE_TIMEOUT consecutive cycles with owner REQ low.
- TURN -> IDLE after exactly one cycle.
REQ-006 SHALL assert GNT[owner] only in BURST, from the cycle after the IDLE decision.
REQ-007 SHALL count a beat in any cycle where GNT[i] and REQ[i] are both high.
- On a beat: enb=1, and addrb, dinb, web are driven combinationally from requester i.
- With no beat: enb=0, web=0, and addrb/dinb hold their previous value.
REQ-008 SHALL treat a beat with REQ_WE==0 as a read.
- RVALID[i] is asserted in the following cycle, with RDATA=doutb.
- RVALID is asserted for exactly one cycle per read beat, including the final beat before TURN.
REQ-009 SHALL never assert RVALID for a write beat.
REQ-010 SHALL set PTR = (owner+1) mod NREQ on entering TURN.
REQ-011 SHALL keep a beat counter, 0..MAX_BURST-1, that increments per beat and clears on entering BURST.
REQ-012 SHALL keep an idle counter that increments while in BURST with owner REQ low, and clears on any beat.
REQ-013 SHALL force release when the beat counter hits MAX_BURST without LAST.
- No error is flagged.
- The requester re-arbitrates normally and is not given priority.
REQ-014 SHALL set ERR_TIMEOUT on timeout release; it is cleared only by reset.
REQ-015 SHALL, when LAST and the MAX_BURST limit coincide, release once and not flag an error.
REQ-016 SHALL ignore REQ changes by non-owners during BURST; they are sampled only in IDLE.

Reset
REQ-017 SHALL, on RSTN low, immediately set state=IDLE, PTR=0, counters=0, ERR_TIMEOUT=0, GNT=0, RVALID=0, enb=0, web=0, addrb=0, dinb=0, RDATA=0.
REQ-018 SHALL, on reset mid-burst, abort the burst and drop any pending RVALID.

Structure
REQ-019 SHALL place the state enum, the NREQ/MAX_BURST/IDLE_TIMEOUT defaults and the requester index constants in a shared package.
REQ-020 SHALL implement the round-robin pick as one combinational sub-module, bram_rr_select (inputs REQ and PTR; outputs one-hot and index).

Verification
REQ-021 SHALL cover the following directed scenarios.
- Single read: REQ[0]=1, ADDR=0x10, WE=0, LAST=1 -> GNT[0] in cycle 2, enb=1, then RVALID[0]=1 with RDATA=mem[0x10] in cycle 3, then TURN, then IDLE.
- Contention: REQ[0..2] raised together, each with a 2-beat burst -> grant order 0, 1, 2, with one TURN cycle between grants.
- Write burst: requester 1 sends 4 writes of 0xA5A5A5A5, WE=0xF, to 0x20..0x2C -> memory updated and no RVALID.
- Fairness: requester 2 holds REQ with no LAST -> released after 16 beats with ERR_TIMEOUT=0, and a pending requester 0 is granted next.
- Timeout: owner drops REQ for 16 cycles -> TURN entered and ERR_TIMEOUT=1, still set 100 cycles later.
- Reset mid-burst: RSTN low after 3 read beats -> GNT=0, RVALID=0 in the same cycle; after release, the first grant goes to the lowest-index requester.
